// File: rtl/jam_cost_server_if.sv
// Bus bundle between the cost server and its peers: table/golden load stream
// plus the JAM lookup and result signals.
interface jam_cost_server_if;
    logic       load_valid;
    logic       load_ready;
    logic [6:0] load_data;
    logic [8:0] gold_min_cost;
    logic [3:0] gold_match_count;
    logic       jam_rst;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       Valid;
    logic [8:0] MinCost;
    logic [3:0] MatchCount;

    modport slave (
        input  load_valid, load_data, gold_min_cost, gold_match_count,
        input  W, J, Valid, MinCost, MatchCount,
        output load_ready, jam_rst, Cost
    );

    modport master (
        output load_valid, load_data, gold_min_cost, gold_match_count,
        output W, J, Valid, MinCost, MatchCount,
        input  load_ready, jam_rst, Cost
    );
endinterface

// File: rtl/jam_cost_server.sv
// Cost-table responder and result checker for JAM bring-up: loads the table,
// releases JAM from reset, serves W/J lookups and grades the first result.
//
// state | meaning
// ------+-----------------------------------------------------------------
// LOAD  | accepting 64 table beats; golden values latched on the last one
// HOLD  | table full, JAM still held in reset for HOLD_CYCLES cycles
// RUN   | JAM running; counting cycles, waiting for Valid or timeout
// DONE  | verdict frozen until RST; lookups still served
module jam_cost_server #(
    parameter int HOLD_CYCLES = 2,        // must be >= 1
    parameter int TIMEOUT     = 10000000,
    parameter int CNT_W       = 24
) (
    input  logic             CLK,
    input  logic             RST,
    jam_cost_server_if.slave bus,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   run_q, run_d, run_inc;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               to_q, to_d;
    logic [8:0]         gmin_q, gmin_d;
    logic [3:0]         gcnt_q, gcnt_d;
    logic               jam_rst_q;
    logic [2:0]         w_q, j_q;
    logic               tbl_we;
    logic [6:0]         tbl [64];

    assign run_inc = run_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        run_d   = run_q;
        done_d  = done_q;
        pass_d  = pass_q;
        to_d    = to_q;
        gmin_d  = gmin_q;
        gcnt_d  = gcnt_q;
        tbl_we  = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (bus.load_valid) begin
                    tbl_we = 1'b1;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        gmin_d  = bus.gold_min_cost;
                        gcnt_d  = bus.gold_match_count;
                        hold_d  = HOLD_LAST;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RUN: begin
                // A result arriving on the timeout cycle still counts as a result.
                if (bus.Valid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (bus.MinCost == gmin_q) && (bus.MatchCount == gcnt_q);
                    to_d    = 1'b0;
                end else begin
                    run_d = run_inc;
                    if (run_inc == TIMEOUT_C) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                        to_d    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_LOAD;
            idx_q     <= '0;
            hold_q    <= '0;
            run_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            to_q      <= 1'b0;
            gmin_q    <= '0;
            gcnt_q    <= '0;
            jam_rst_q <= 1'b1;
            w_q       <= '0;
            j_q       <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            run_q     <= run_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            to_q      <= to_d;
            gmin_q    <= gmin_d;
            gcnt_q    <= gcnt_d;
            jam_rst_q <= !((state_d == S_RUN) || (state_d == S_DONE));
            w_q       <= bus.W;
            j_q       <= bus.J;
        end
    end

    // Table storage is deliberately not reset; a full reload always follows RST.
    always_ff @(posedge CLK) begin
        if (tbl_we && !RST) begin
            tbl[idx_q] <= bus.load_data;
        end
    end

    assign bus.Cost       = tbl[{w_q, j_q}];
    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.jam_rst    = jam_rst_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = to_q;
    assign run_cycles     = run_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized scoreboard bench for jam_cost_server: a spec-level model predicts
// handshake/reset behaviour, lookup costs and the final verdict.
module tb_jam_cost_server;
    localparam int HOLD = 2;
    localparam int TMO  = 120;
    localparam int CW   = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          done, pass, timeout;
    logic [CW-1:0] run_cycles;

    jam_cost_server_if bus();

    jam_cost_server #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .run_cycles (run_cycles)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        bit p;
        bit t;
        int rc;
    } res_t;

    // reference model state
    logic [6:0] ref_tbl [64];
    int         n_acc = 0;
    int         m = 0;
    bit         loaded = 0;
    bit         any_written = 0;
    bit         done_m = 0;
    bit         e_pass = 0;
    bit         e_to = 0;
    int         rc_f = 0;
    logic [8:0] g_min, ref_gmin;
    logic [3:0] g_cnt, ref_gcnt;
    int         v_at = -1;
    logic [8:0] v_mc;
    logic [3:0] v_cnt;
    bit         spam = 0;
    bit         lk_req = 0;
    bit         lk_fire = 0;
    logic [6:0] cost_q [$];
    res_t       res_q [$];
    logic [5:0] fw_q [$];

    task automatic step(input bit lv, input logic [6:0] ld);
        int         rc;
        bit         run;
        bit         vv;
        logic [5:0] wj;
        @(negedge CLK);
        if (loaded) m++;
        run = loaded && (m > HOLD);
        rc  = run ? (m - HOLD - 1) : 0;
        chk("load_ready", bus.load_ready, !loaded);
        chk("jam_rst", bus.jam_rst, !run);
        chk("done", done, done_m);
        chk("pass", pass, done_m ? e_pass : 1'b0);
        chk("timeout", timeout, done_m ? e_to : 1'b0);
        chk("run_cycles", run_cycles, done_m ? rc_f : rc);

        bus.load_valid       = lv;
        bus.load_data        = ld;
        bus.gold_min_cost    = 9'($urandom);
        bus.gold_match_count = 4'($urandom);
        if (lv && !loaded) begin
            ref_tbl[n_acc] = ld;
            any_written = 1;
            if (n_acc == 63) begin
                bus.gold_min_cost    = g_min;
                bus.gold_match_count = g_cnt;
                ref_gmin = g_min;
                ref_gcnt = g_cnt;
                loaded = 1;
                m = 0;
            end
            n_acc++;
        end

        vv = 0;
        bus.MinCost    = 9'($urandom);
        bus.MatchCount = 4'($urandom);
        if (run && !done_m && rc == v_at) begin
            vv = 1;
            bus.MinCost    = v_mc;
            bus.MatchCount = v_cnt;
        end else if (done_m && spam) begin
            vv = 1;
            bus.MinCost    = 9'd5;
            bus.MatchCount = ref_gcnt;
        end else if (!run) begin
            vv = 1'($urandom_range(0, 1));
        end
        bus.Valid = vv;

        if (run && !done_m) begin
            if (vv) begin
                done_m = 1;
                e_pass = (v_mc == ref_gmin) && (v_cnt == ref_gcnt);
                e_to   = 0;
                rc_f   = rc;
                res_q.push_back('{p: e_pass, t: 1'b0, rc: rc});
            end else if (rc + 1 == TMO) begin
                done_m = 1;
                e_pass = 0;
                e_to   = 1;
                rc_f   = TMO;
                res_q.push_back('{p: 1'b0, t: 1'b1, rc: TMO});
            end
        end

        lk_req = loaded;
        if (loaded) begin
            wj = (fw_q.size() != 0) ? fw_q.pop_front() : 6'($urandom);
            bus.W = wj[5:3];
            bus.J = wj[2:0];
            cost_q.push_back(ref_tbl[wj]);
        end else begin
            bus.W = 3'($urandom);
            bus.J = 3'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST = 1;
        bus.load_valid = 0;
        bus.Valid = 0;
        lk_req = 0;
        n_acc = 0;
        loaded = 0;
        m = 0;
        done_m = 0;
        spam = 0;
        v_at = -1;
        fw_q.delete();
        repeat (n) @(negedge CLK);
        chk("rst_load_ready", bus.load_ready, 1);
        chk("rst_jam_rst", bus.jam_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_run_cycles", run_cycles, 0);
        if (any_written) chk("rst_cost_wq0", bus.Cost, ref_tbl[0]);
        RST = 0;
    endtask

    task automatic run_until_done();
        for (int k = 0; k < 400 && !done_m; k++) step(1'($urandom_range(0, 1)), 7'($urandom));
        step(0, 7'd0);
        chk("done_reached", done, 1);
        chk("res_q_drained", res_q.size(), 0);
    endtask

    task automatic load_random_valid();
        for (int k = 0; k < 600 && !loaded; k++) step(1'($urandom_range(0, 1)), 7'($urandom));
    endtask

    // monitor: pops expectations whenever a lookup result or verdict appears
    always @(posedge CLK) lk_fire <= lk_req;

    initial begin : monitor
        bit   done_prev;
        res_t r;
        done_prev = 0;
        forever begin
            @(negedge CLK);
            if (lk_fire) begin
                if (cost_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL cost_q: lookup result with no expected entry, Cost=%0d", bus.Cost);
                end else begin
                    chk("Cost", bus.Cost, cost_q.pop_front());
                end
            end
            if (done && !done_prev) begin
                if (res_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL verdict: done rose unexpectedly pass=%0d timeout=%0d", pass, timeout);
                end else begin
                    r = res_q.pop_front();
                    chk("verdict_pass", pass, r.p);
                    chk("verdict_timeout", timeout, r.t);
                    chk("verdict_run_cycles", run_cycles, r.rc);
                end
            end
            done_prev = done;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.load_valid = 0;
        bus.load_data = 0;
        bus.gold_min_cost = 0;
        bus.gold_match_count = 0;
        bus.W = 0;
        bus.J = 0;
        bus.Valid = 0;
        bus.MinCost = 0;
        bus.MatchCount = 0;

        // held-high load, idx mod 100, passing result then ignored Valids
        do_reset(3);
        g_min = 9'd200;
        g_cnt = 4'd3;
        for (int i = 0; i < 64; i++) step(1, 7'(i % 100));
        fw_q.push_back(6'd29);
        fw_q.push_back(6'd63);
        v_at = 100; v_mc = 9'd200; v_cnt = 4'd3;
        run_until_done();
        spam = 1;
        repeat (10) step(1, 7'($urandom));

        // toggling load_valid, MinCost off by one
        do_reset(2);
        g_min = 9'd200;
        g_cnt = 4'd3;
        for (int i = 0; i < 200 && !loaded; i++) step(i % 2 == 0, 7'($urandom));
        fw_q.push_back(6'd63);
        fw_q.push_back(6'd29);
        v_at = 100; v_mc = 9'd201; v_cnt = 4'd3;
        run_until_done();
        spam = 1;
        repeat (5) step(0, 7'd0);

        // random load, no result: timeout
        do_reset(1);
        g_min = 9'($urandom);
        g_cnt = 4'($urandom);
        load_random_valid();
        run_until_done();
        spam = 1;
        repeat (5) step(0, 7'd0);

        // Valid on the timeout cycle wins
        do_reset(2);
        g_min = 9'($urandom_range(0, 1016));
        g_cnt = 4'($urandom);
        for (int i = 0; i < 64; i++) step(1, 7'($urandom));
        v_at = TMO - 1; v_mc = g_min; v_cnt = g_cnt;
        run_until_done();
        repeat (3) step(0, 7'd0);

        // RST during HOLD, then during RUN; reload required each time
        do_reset(2);
        g_min = 9'($urandom);
        g_cnt = 4'($urandom);
        for (int i = 0; i < 64; i++) step(1, 7'($urandom));
        step(1, 7'd0);
        do_reset(2);
        for (int i = 0; i < 30; i++) step(1, 7'($urandom));
        repeat (10) step(0, 7'd0);
        for (int i = 0; i < 34; i++) step(1, 7'($urandom));
        repeat (25) step(1'($urandom_range(0, 1)), 7'($urandom));
        do_reset(2);
        repeat (5) step(0, 7'd0);
        g_min = 9'($urandom);
        g_cnt = 4'($urandom);
        load_random_valid();
        v_at = 37; v_mc = g_min; v_cnt = g_cnt ^ 4'd1;
        run_until_done();

        do_reset(2);
        chk("cost_q_empty", cost_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
